st7920_fb_arbiter: RTL and testbench

Owns the 1024×8 ST7920 framebuffer and shares its single access slot between three requesters. The serial refresh reader uses one read port; game/draw logic uses two write ports. Each write port may optionally invert bits in place with an XOR. The block sits between the top-level drawing logic and `st7920_serial_driver`, replacing direct array access.

---
 rtl/st7920_fb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_st7920_fb_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/st7920_fb_arbiter.sv
// st7920_fb_arbiter
// Owns the 1024x8 ST7920 framebuffer and time-shares its single access slot
// between the serial refresh reader (one read port) and two draw/game write
// ports. Reads win by default, but a read grant is always followed by a
// writer grant when one is pending. Writers alternate round-robin.
//
// Build option: define ST7920_FB_XOR_EN to build the in-place XOR
// (read-modify-write) path and drive `busy`. Without it, wa_xor/wb_xor are
// ignored, every write is plain and `busy` is tied low.
//
// Grants and acks are combinational from the requests in the grant cycle.
// They are gated by the reset, so every output reads 0 while reset is held.

module st7920_fb_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n_ms,
  // refresh reader
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  // writer A
  input  logic              wa_req,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wa_xor,
  output logic              wa_ack,
  // writer B
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_xor,
  output logic              wb_ack,
  output logic              busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RMW  = 1'b1;

  localparam logic W_A = 1'b0;
  localparam logic W_B = 1'b1;

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] mem_q;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  logic [0:0]        state_q;
  logic              last_w_q;
  logic              prev_rd_q;
  logic [DATA_W-1:0] rd_hold_q;

  logic              idle;
  logic              in_rmw;
  logic              wr_pend;
  logic              gnt_rd;
  logic              gnt_w;
  logic              w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_xor;
  logic              gnt_xor;
  logic              gnt_plain;
  logic              rmw_port_q;
  logic [ADDR_W-1:0] rmw_addr_q;
  logic [DATA_W-1:0] rmw_mask_q;

  // A grant can only be issued in IDLE and never while reset is asserted.
  assign idle    = (state_q == S_IDLE) && sys_rst_n_ms;
  assign in_rmw  = (state_q == S_RMW);
  assign wr_pend = wa_req | wb_req;

  // Read wins unless the previous grant was a read and a writer is waiting.
  assign gnt_rd = idle && rd_req && !(prev_rd_q && wr_pend);
  assign gnt_w  = idle && wr_pend && !gnt_rd;

  // Round-robin: with both writers pending, the one not served last wins.
  assign w_sel  = (wa_req && wb_req) ? ~last_w_q : (wa_req ? W_A : W_B);
  assign w_addr = (w_sel == W_A) ? wa_addr : wb_addr;
  assign w_data = (w_sel == W_A) ? wa_data : wb_data;

`ifdef ST7920_FB_XOR_EN
  assign w_xor   = (w_sel == W_A) ? wa_xor : wb_xor;
  assign gnt_xor = gnt_w && w_xor;

  // RMW sequencing: capture the XOR target in the grant cycle, write back
  // old^mask on the following cycle. Reset drops a pending write-back.
  always_ff @(posedge sys_clk or negedge sys_rst_n_ms) begin
    if (!sys_rst_n_ms) begin
      state_q    <= S_IDLE;
      rmw_port_q <= W_A;
      rmw_addr_q <= '0;
      rmw_mask_q <= '0;
    end else if (gnt_xor) begin
      state_q    <= S_RMW;
      rmw_port_q <= w_sel;
      rmw_addr_q <= w_addr;
      rmw_mask_q <= w_data;
    end else begin
      state_q    <= S_IDLE;
    end
  end

  // In RMW, mem_q holds the old byte read during the grant cycle.
  assign mem_wdata = in_rmw ? (mem_q ^ rmw_mask_q) : w_data;
`else
  logic unused_xor;
  assign unused_xor = wa_xor ^ wb_xor;

  assign w_xor      = 1'b0;
  assign gnt_xor    = 1'b0;
  assign state_q    = S_IDLE;
  assign rmw_port_q = W_A;
  assign rmw_addr_q = '0;
  assign rmw_mask_q = '0;
  assign mem_wdata  = w_data;
`endif

  assign gnt_plain = gnt_w && !gnt_xor;

  // Single array port: the RMW write-back owns it, else the current grant.
  assign mem_addr = in_rmw ? rmw_addr_q : (gnt_rd ? rd_addr : w_addr);
  assign mem_we   = gnt_plain | in_rmw;

  // Framebuffer array with synchronous read.
  // NOTE: the array has no reset; clearing 1024 bytes would need a sweep and
  // the display contents are rewritten by the draw logic anyway.
  always_ff @(posedge sys_clk) begin
    mem_q <= mem[mem_addr];
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Arbitration history and read-return bookkeeping.
  // NOTE: all state here uses non-blocking assignment so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n_ms) begin
    if (!sys_rst_n_ms) begin
      last_w_q  <= W_B;
      prev_rd_q <= 1'b0;
      rd_valid  <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      if (gnt_rd) begin
        prev_rd_q <= 1'b1;
      end else if (gnt_w) begin
        prev_rd_q <= 1'b0;
        last_w_q  <= w_sel;
      end
      rd_valid <= gnt_rd;
      if (rd_valid) begin
        rd_hold_q <= mem_q;
      end
    end
  end

  // Fresh byte in the valid cycle, then held until the next read returns.
  assign rd_data = rd_valid ? mem_q : rd_hold_q;

  assign rd_ack = gnt_rd;
  assign wa_ack = (gnt_plain && (w_sel == W_A)) || (in_rmw && (rmw_port_q == W_A));
  assign wb_ack = (gnt_plain && (w_sel == W_B)) || (in_rmw && (rmw_port_q == W_B));
  assign busy   = in_rmw;

endmodule

// File: tb/tb_st7920_fb_arbiter.sv
// Directed self-checking bench for st7920_fb_arbiter. Expected values are
// hand-computed; the XOR cases choose expectations by ST7920_FB_XOR_EN.

module tb_st7920_fb_arbiter;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n_ms;
  logic       rd_req;
  logic [9:0] rd_addr;
  logic       rd_ack;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       wa_req, wb_req;
  logic [9:0] wa_addr, wb_addr;
  logic [7:0] wa_data, wb_data;
  logic       wa_xor, wb_xor;
  logic       wa_ack, wb_ack;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  st7920_fb_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n_ms (sys_rst_n_ms),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .wa_req       (wa_req),
    .wa_addr      (wa_addr),
    .wa_data      (wa_data),
    .wa_xor       (wa_xor),
    .wa_ack       (wa_ack),
    .wb_req       (wb_req),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_xor       (wb_xor),
    .wb_ack       (wb_ack),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Writer A request held until ack, then dropped after the ack edge.
  task automatic write_a(input logic [9:0] a, input logic [7:0] d, input logic x);
    bit got = 0;
    step();
    wa_req = 1'b1; wa_addr = a; wa_data = d; wa_xor = x;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (wa_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) check("wa_ack_timeout", 32'd0, 32'd1);
    step();
    wa_req = 1'b0; wa_xor = 1'b0;
  endtask

  // Read request held until ack; returns the byte seen in the valid cycle.
  task automatic read_byte(input logic [9:0] a, output logic [7:0] d);
    bit got = 0;
    step();
    rd_req = 1'b1; rd_addr = a;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (rd_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) check("rd_ack_timeout", 32'd0, 32'd1);
    step();
    rd_req = 1'b0;
    @(negedge sys_clk);
    check("rd_valid_pulse", {31'd0, rd_valid}, 32'd1);
    d = rd_data;
  endtask

  logic [7:0] rbyte;
  logic [2:0] acks;
  logic [2:0] exp_order [6];

  initial begin
    exp_order[0] = 3'b100; exp_order[1] = 3'b010; exp_order[2] = 3'b100;
    exp_order[3] = 3'b001; exp_order[4] = 3'b100; exp_order[5] = 3'b010;

    sys_rst_n_ms = 1'b0;
    rd_req = 1'b1; rd_addr = '0;
    wa_req = 1'b0; wa_addr = '0; wa_data = '0; wa_xor = 1'b0;
    wb_req = 1'b0; wb_addr = '0; wb_data = '0; wb_xor = 1'b0;

    // Reset state: everything low even with a read request pending.
    #2;
    check("rst_rd_ack",   {31'd0, rd_ack},   32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data",  {24'd0, rd_data},  32'd0);
    check("rst_acks",     {29'd0, wa_ack, wb_ack, busy}, 32'd0);
    rd_req = 1'b0;
    step();
    step();
    sys_rst_n_ms = 1'b1;

    // Plain write at the top address, then read it back.
    step();
    wa_req = 1'b1; wa_addr = 10'h3FF; wa_data = 8'h5A;
    @(negedge sys_clk);
    check("pw_wa_ack_grant", {31'd0, wa_ack}, 32'd1);
    check("pw_busy", {31'd0, busy}, 32'd0);
    step();
    wa_req = 1'b0;
    rd_req = 1'b1; rd_addr = 10'h3FF;
    @(negedge sys_clk);
    check("pw_rd_ack_next", {31'd0, rd_ack}, 32'd1);
    step();
    rd_req = 1'b0;
    @(negedge sys_clk);
    check("pw_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("pw_rd_data", {24'd0, rd_data}, 32'h5A);
    step();
    @(negedge sys_clk);
    check("rd_valid_one_cycle", {31'd0, rd_valid}, 32'd0);
    check("rd_data_hold", {24'd0, rd_data}, 32'h5A);

    // Same-address read/write conflict: read first with the old byte.
    write_a(10'h010, 8'h00, 1'b0);
    rd_req = 1'b1; rd_addr = 10'h010;
    wa_req = 1'b1; wa_addr = 10'h010; wa_data = 8'h11;
    @(negedge sys_clk);
    check("cf_rd_first", {30'd0, rd_ack, wa_ack}, 32'b10);
    step();
    rd_req = 1'b0;
    @(negedge sys_clk);
    check("cf_old_byte", {24'd0, rd_data}, 32'h00);
    check("cf_wa_second", {30'd0, rd_ack, wa_ack}, 32'b01);
    step();
    wa_req = 1'b0;
    read_byte(10'h010, rbyte);
    check("cf_new_byte", {24'd0, rbyte}, 32'h11);

    // Saturation from reset: grant order R A R B R A, one ack per cycle.
    step();
    sys_rst_n_ms = 1'b0;
    rd_req = 1'b1; rd_addr = 10'h3FF;
    wa_req = 1'b1; wa_addr = 10'h100; wa_data = 8'h01;
    wb_req = 1'b1; wb_addr = 10'h101; wb_data = 8'h02;
    step();
    sys_rst_n_ms = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      acks = {rd_ack, wa_ack, wb_ack};
      check($sformatf("sat_grant_%0d", i), {29'd0, acks}, {29'd0, exp_order[i]});
      step();
    end
    rd_req = 1'b0; wa_req = 1'b0; wb_req = 1'b0;
    read_byte(10'h101, rbyte);
    check("sat_wb_data", {24'd0, rbyte}, 32'h02);

    // XOR write on 0xF0 with mask 0xFF.
    write_a(10'h020, 8'hF0, 1'b0);
    wa_req = 1'b1; wa_addr = 10'h020; wa_data = 8'hFF; wa_xor = 1'b1;
    @(negedge sys_clk);
`ifdef ST7920_FB_XOR_EN
    check("x_grant_no_ack", {30'd0, wa_ack, busy}, 32'b00);
    step();
    @(negedge sys_clk);
    check("x_rmw_ack_busy", {30'd0, wa_ack, busy}, 32'b11);
    step();
    wa_req = 1'b0; wa_xor = 1'b0;
    @(negedge sys_clk);
    check("x_after_busy", {30'd0, wa_ack, busy}, 32'b00);
    read_byte(10'h020, rbyte);
    check("x_result", {24'd0, rbyte}, 32'h0F);
`else
    check("x_grant_ack", {30'd0, wa_ack, busy}, 32'b10);
    step();
    wa_req = 1'b0; wa_xor = 1'b0;
    @(negedge sys_clk);
    check("x_after_busy", {30'd0, wa_ack, busy}, 32'b00);
    read_byte(10'h020, rbyte);
    check("x_result", {24'd0, rbyte}, 32'hFF);
`endif

    // Reset during the cycle after an XOR grant.
    write_a(10'h020, 8'hF0, 1'b0);
    wa_req = 1'b1; wa_addr = 10'h020; wa_data = 8'hFF; wa_xor = 1'b1;
    step();
    #1;
    sys_rst_n_ms = 1'b0;
    #1;
    check("mr_outputs_zero", {26'd0, rd_ack, rd_valid, wa_ack, wb_ack, busy, |rd_data}, 32'd0);
    step();
    wa_req = 1'b0; wa_xor = 1'b0;
    sys_rst_n_ms = 1'b1;
    read_byte(10'h020, rbyte);
`ifdef ST7920_FB_XOR_EN
    check("mr_mem_kept", {24'd0, rbyte}, 32'hF0);
`else
    check("mr_mem_plain", {24'd0, rbyte}, 32'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
